// File: rtl/fp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_sched_pkg
// Purpose  : Shared types and constants for the shared fp-adder scheduler.
//            fp32_t  - IEEE-754 single-precision word
//            tag_t   - {vld, id} record that follows each add down the pipe
// Revision : 1.0  initial release
// ============================================================================
package fp_sched_pkg;

    localparam int FP_W            = 32;
    localparam int DEFAULT_ADD_LAT = 10;
    // Widest requester id the tag record can carry (NREQ up to 16).
    localparam int MAX_IDW         = 4;

    typedef logic [FP_W-1:0] fp32_t;

    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
// Module   : fp_add
// Purpose  : Pipelined single-precision adder, fixed latency, no stall, no reset.
//            Round-to-nearest-even; subnormal inputs/results flush to zero;
//            an Inf/NaN operand with the larger magnitude is passed through.
// Ports    : clk    in  1   clock
//            dataa  in  32  operand A
//            datab  in  32  operand B
//            result out 32  A+B, STAGES register stages after the inputs
// Revision : 1.0  initial release
// ============================================================================
module fp_add
    import fp_sched_pkg::*;
#(
    parameter int STAGES = DEFAULT_ADD_LAT
) (
    input  logic  clk,
    input  fp32_t dataa,
    input  fp32_t datab,
    output fp32_t result
);

    logic        a_big;
    fp32_t       big, sml, res;
    logic [7:0]  exp_big, exp_sml, shamt;
    logic [26:0] man_big, man_sml, man_sh, lost_mask, norm;
    logic        sticky, found;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_r;
    logic [24:0] rnd;
    logic [22:0] frac;

    always_comb begin
        // Order by magnitude so the subtract path never goes negative.
        a_big   = dataa[30:0] >= datab[30:0];
        big     = a_big ? dataa : datab;
        sml     = a_big ? datab : dataa;
        exp_big = big[30:23];
        exp_sml = sml[30:23];
        // Mantissa with hidden bit plus guard/round/sticky positions.
        man_big = (exp_big == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
        man_sml = (exp_sml == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
        shamt   = exp_big - exp_sml;
        // Bits shifted out of the small operand collapse into the sticky LSB.
        lost_mask = ~(27'h7FF_FFFF << shamt);
        sticky    = |(man_sml & lost_mask);
        man_sh    = man_sml >> shamt;
        man_sh[0] = man_sh[0] | sticky;

        if (big[31] == sml[31])
            sum = {1'b0, man_big} + {1'b0, man_sh};
        else
            sum = {1'b0, man_big} - {1'b0, man_sh};

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, exp_big} + 10'd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = {2'b00, exp_big} - {5'd0, lz};
        end

        rnd   = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[3] | norm[1] | norm[0])};
        exp_r = rnd[24] ? exp_n + 10'd1 : exp_n;
        frac  = rnd[24] ? rnd[23:1] : rnd[22:0];
        res   = {big[31], exp_r[7:0], frac};

        if (exp_big == 8'hFF)
            res = big;
        else if (!sum[27] && !found)
            res = '0;                               // exact cancellation or zeros
        else if (exp_r[9] || exp_r == 10'd0)
            res = {big[31], 31'd0};                 // underflow flushes to zero
        else if (exp_r >= 10'd255)
            res = {big[31], 8'hFF, 23'd0};          // overflow to infinity
    end

    fp32_t pipe [STAGES];

    always_ff @(posedge clk) begin
        pipe[0] <= res;
        for (int s = 1; s < STAGES; s++)
            pipe[s] <= pipe[s-1];
    end

    assign result = pipe[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fp_add_sched_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set request at or after ptr.
// Ports    : req   in  NREQ  request vector
//            ptr   in  IDW   highest-priority index this cycle
//            grant out NREQ  one-hot grant, zero when no request
//            id    out IDW   encoded index of the grant
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                id         = IDW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_sched
// Purpose  : Shares one pipelined fp_add among NREQ requesters. Round-robin
//            issue of at most one add per cycle; a {vld,id} tag pipe of the
//            same depth as the adder routes each sum back to its issuer.
// Ports    : clk       in  1        clock
//            rst_n     in  1        synchronous active-low reset
//            req_valid in  NREQ     add pending per requester
//            req_ready out NREQ     one-hot grant (transfer = valid & ready)
//            req_a     in  NREQx32  operand A, requester i at [32i +: 32]
//            req_b     in  NREQx32  operand B
//            rsp_valid out NREQ     one-cycle result pulse for requester i
//            rsp_data  out 32       sum, meaningful while |rsp_valid
//            busy      out 1        any add in flight
//            inflight  out CNTW     number of adds in flight
// Revision : 1.0  initial release
// ============================================================================
module fp_add_sched
    import fp_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int ADD_LAT = DEFAULT_ADD_LAT,
    localparam int IDW     = $clog2(NREQ),
    localparam int CNTW    = $clog2(ADD_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    output fp32_t                rsp_data,
    output logic                 busy,
    output logic [CNTW-1:0]      inflight
);

    logic [IDW-1:0]  ptr, gnt_id;
    logic [NREQ-1:0] grant, rsp_dec;
    logic            transfer, retire;
    fp32_t           op_a, op_b, sum;
    tag_t            tags [ADD_LAT];
    logic [CNTW-1:0] count;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .id    (gnt_id)
    );

    // Grant is gated off while reset is asserted so nothing is accepted then.
    assign req_ready = rst_n ? grant : '0;
    assign transfer  = |req_ready;

    // Idle cycles feed zeros; that result is masked by a cleared vld bit.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                op_a = req_a[i*FP_W +: FP_W];
                op_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    // The adder's register chain and the tag pipe have equal depth, so the
    // last tag stage and the adder output line up in the same cycle.
    fp_add #(.STAGES(ADD_LAT)) u_add (
        .clk    (clk),
        .dataa  (op_a),
        .datab  (op_b),
        .result (sum)
    );

    assign retire = tags[ADD_LAT-1].vld;

    always_comb begin
        rsp_dec = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_dec[i] = retire && (tags[ADD_LAT-1].id == MAX_IDW'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            count     <= '0;
            for (int s = 0; s < ADD_LAT; s++)
                tags[s] <= '0;
        end else begin
            if (transfer)
                ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

            tags[0].vld <= transfer;
            tags[0].id  <= MAX_IDW'(gnt_id);
            for (int s = 1; s < ADD_LAT; s++)
                tags[s] <= tags[s-1];

            rsp_valid <= rsp_dec;
            if (retire)
                rsp_data <= sum;

            case ({transfer, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign inflight = count;
    assign busy     = (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_sched
// Purpose  : Self-checking bench for fp_add_sched (NREQ=4, ADD_LAT=10).
//            Every accepted add pushes its expected {id, sum, arrival cycle}
//            into a queue; each response pulse pops and compares one entry.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_add_sched;

    localparam int NREQ    = 4;
    localparam int ADD_LAT = 10;
    localparam int CW      = $clog2(ADD_LAT + 1);

    localparam logic [31:0] F_1P0  = 32'h3F800000;
    localparam logic [31:0] F_2P0  = 32'h40000000;
    localparam logic [31:0] F_3P0  = 32'h40400000;
    localparam logic [31:0] F_0P5  = 32'h3F000000;
    localparam logic [31:0] F_1P5  = 32'h3FC00000;
    localparam logic [31:0] F_M1P0 = 32'hBF800000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_data;
    logic                 busy;
    logic [CW-1:0]        inflight;

    fp_add_sched #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t e_push, e_pop;
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   exp_ptr = 0;

    // Reference sums for the operand pairs used below.
    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {F_1P0, F_2P0}, {F_2P0, F_1P0}: return F_3P0;
            {F_0P5, F_1P0}, {F_1P0, F_0P5}: return F_1P5;
            {F_3P0, F_M1P0}:                return F_2P0;
            {F_1P5, F_1P5}:                 return F_3P0;
            {F_1P0, F_1P0}:                 return F_2P0;
            default:                        return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Scoreboard: push on accepted transfers, pop/compare on response pulses.
    task automatic scoreboard();
        if (rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e_push.id   = i;
                    e_push.data = exp_sum(req_a[i*32 +: 32], req_b[i*32 +: 32]);
                    e_push.due  = cyc + 1 + ADD_LAT;
                    q.push_back(e_push);
                end
            end
            if (rsp_valid !== '0) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, no add outstanding", rsp_valid, rsp_data);
                end else begin
                    e_pop = q.pop_front();
                    if (rsp_valid !== NREQ'(1 << e_pop.id) || rsp_data !== e_pop.data || cyc != e_pop.due) begin
                        fails++;
                        $display("FAIL rsp_match: got valid=%b data=%h cyc=%0d, expected valid=%b data=%h cyc=%0d",
                                 rsp_valid, rsp_data, cyc, NREQ'(1 << e_pop.id), e_pop.data, e_pop.due);
                    end
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                tests++;
                fails++;
                e_pop = q.pop_front();
                $display("FAIL rsp_missing: no rsp at cyc=%0d, expected id=%0d data=%h", cyc, e_pop.id, e_pop.data);
            end
        end
    endtask

    // One clock: scoreboard on the falling edge, then 1ns past the rising edge.
    task automatic step();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        step();
        step();
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready);
        end
        tests++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0 || inflight !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rsp_valid=%b rsp_data=%h inflight=%0d busy=%b expected 0/0/0/0",
                     rsp_valid, rsp_data, inflight, busy);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL reset_ptr: req_ready=%b expected 0001", req_ready);
        end
        req_valid = '0;
        exp_ptr   = 0;
    endtask

    task automatic test_single();
        set_op(0, F_1P0, F_2P0);
        req_valid = 4'b0001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL single_ready: req_ready=%b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        exp_ptr   = 1;
        tests++;
        if (inflight !== CW'(1) || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_issue: inflight=%0d busy=%b expected 1/1", inflight, busy);
        end
        for (int j = 1; j < ADD_LAT; j++) begin
            step();
            tests++;
            if (rsp_valid !== 4'b0000 || inflight !== CW'(1)) begin
                fails++;
                $display("FAIL single_gap: cycle %0d rsp_valid=%b inflight=%0d expected 0000/1", j, rsp_valid, inflight);
            end
        end
        step();
        tests++;
        if (rsp_valid !== 4'b0001 || rsp_data !== F_3P0) begin
            fails++;
            $display("FAIL single_rsp: rsp_valid=%b rsp_data=%h expected 0001/%h", rsp_valid, rsp_data, F_3P0);
        end
        tests++;
        if (inflight !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_retire: inflight=%0d busy=%b expected 0/0", inflight, busy);
        end
        drain();
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] exp_rdy;
        set_op(0, F_1P0, F_2P0);
        set_op(1, F_0P5, F_1P0);
        set_op(2, F_3P0, F_M1P0);
        set_op(3, F_1P5, F_1P5);
        req_valid = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = NREQ'(1 << exp_ptr);
            tests++;
            if (req_ready !== exp_rdy) begin
                fails++;
                $display("FAIL contention_grant: cycle %0d req_ready=%b expected %b", c, req_ready, exp_rdy);
            end
            step();
            exp_ptr = (exp_ptr + 1) % NREQ;
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_wrap();
        set_op(2, F_1P0, F_1P0);
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL wrap_setup: req_ready=%b expected 0100", req_ready);
        end
        step();
        req_valid = 4'b1001;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL wrap_first: req_ready=%b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b0001;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_second: req_ready=%b expected 0001", req_ready);
        end
        step();
        req_valid = 4'b0011;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_ptr1: req_ready=%b expected 0010", req_ready);
        end
        step();
        req_valid = '0;
        exp_ptr   = 2;
        drain();
    endtask

    task automatic test_back_to_back();
        int peak;
        peak = 0;
        set_op(1, F_0P5, F_1P0);
        req_valid = 4'b0010;
        for (int c = 0; c < ADD_LAT; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0010) begin
                fails++;
                $display("FAIL b2b_grant: issue %0d req_ready=%b expected 0010", c, req_ready);
            end
            step();
            if (int'(inflight) > peak)
                peak = int'(inflight);
        end
        req_valid = '0;
        tests++;
        if (peak != ADD_LAT) begin
            fails++;
            $display("FAIL b2b_peak: inflight peak=%0d expected %0d", peak, ADD_LAT);
        end
        for (int c = 0; c < ADD_LAT; c++) begin
            step();
            tests++;
            if (rsp_valid !== 4'b0010 || rsp_data !== F_1P5) begin
                fails++;
                $display("FAIL b2b_rsp: pulse %0d rsp_valid=%b rsp_data=%h expected 0010/%h", c, rsp_valid, rsp_data, F_1P5);
            end
        end
        exp_ptr = 2;
        drain();
        tests++;
        if (inflight !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: inflight=%0d busy=%b expected 0/0", inflight, busy);
        end
    endtask

    task automatic test_reset_mid();
        set_op(0, F_1P0, F_1P0);
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0001) begin
                fails++;
                $display("FAIL rstmid_grant: issue %0d req_ready=%b expected 0001", c, req_ready);
            end
            step();
        end
        req_valid = '0;
        tests++;
        if (inflight !== CW'(5)) begin
            fails++;
            $display("FAIL rstmid_count: inflight=%0d expected 5", inflight);
        end
        rst_n = 1'b0;
        q.delete();
        req_valid = 4'b0001;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_ready: req_ready=%b expected 0000 during reset", req_ready);
        end
        req_valid = '0;
        step();
        rst_n   = 1'b1;
        exp_ptr = 0;
        tests++;
        if (inflight !== '0 || busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid_state: inflight=%0d busy=%b rsp_valid=%b expected 0/0/0000", inflight, busy, rsp_valid);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            tests++;
            if (rsp_valid !== 4'b0000) begin
                fails++;
                $display("FAIL rstmid_dropped: cycle %0d rsp_valid=%b expected 0000", c, rsp_valid);
            end
        end
        set_op(2, F_1P0, F_0P5);
        req_valid = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL rstmid_next: req_ready=%b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        exp_ptr   = 3;
        tests++;
        if (inflight !== CW'(1)) begin
            fails++;
            $display("FAIL rstmid_next_count: inflight=%0d expected 1", inflight);
        end
        drain();
    endtask

    task automatic test_idle();
        logic [NREQ-1:0] exp_rdy;
        req_valid = '0;
        for (int c = 0; c < 50; c++) begin
            step();
            tests++;
            if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_quiet: cycle %0d req_ready=%b rsp_valid=%b busy=%b expected 0000/0000/0",
                         c, req_ready, rsp_valid, busy);
            end
        end
        set_op(3, F_1P5, F_1P5);
        req_valid = 4'b1111;
        #1;
        exp_rdy = NREQ'(1 << exp_ptr);
        tests++;
        if (req_ready !== exp_rdy) begin
            fails++;
            $display("FAIL idle_ptr: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        step();
        req_valid = '0;
        exp_ptr   = (exp_ptr + 1) % NREQ;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
